fft_frame_controller: RTL and testbench

Sequences the streaming FFT core that feeds the tone-detection FSM. After reset it sends one configuration word to the FFT, then packs incoming audio samples into frames of FRAME_LEN beats with `last` on the final beat. It allows one frame in flight at a time and waits for the FFT output `last` beat before starting the next frame. It also reports frame completion, overruns and output timeouts.

---
 rtl/fft_frame_controller.sv | 195 +++++++++++++++++++
 tb/tb_fft_frame_controller.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_controller.sv
// rtl/fft_frame_controller.sv - FFT config/frame sequencer with overrun and timeout reporting
//
// Sends one configuration word to a streaming FFT core after reset. It then
// packs audio samples into frames of FRAME_LEN beats, with `last` on the final
// beat. Only one frame is in flight at a time: the next frame may start only
// after the FFT output `last` beat, or after an output timeout.
//
// Parameters: FRAME_LEN (power of two, >= 4), DATA_W (<= 16), CONFIG_WORD,
//             TIMEOUT_CYCLES (>= 2).
// Ports:
//   clk_in, rst_in                    clock, async active-high reset
//   enable_in                         permits starting a new frame
//   sample_in, sample_valid_in        signed sample strobe (no backpressure)
//   fft_config_*                      config word handshake to the FFT
//   fft_in_*                          sample stream to the FFT (imag part = 0)
//   fft_out_valid/ready/last_in       FFT output stream, monitored only
//   frame_done_out, frame_count_out   completion pulse and wrapping count
//   overrun_out, timeout_out          sticky error flags
//   busy_out                          frame in progress (FILL or WAIT_OUT)

module fft_frame_controller #(
    parameter int          FRAME_LEN      = 2048,
    parameter int          DATA_W         = 16,
    parameter logic [15:0] CONFIG_WORD    = 16'h0001,
    parameter int          TIMEOUT_CYCLES = 8192
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enable_in,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid_in,
    output logic [15:0]       fft_config_data_out,
    output logic              fft_config_valid_out,
    input  logic              fft_config_ready_in,
    output logic [31:0]       fft_in_data_out,
    output logic              fft_in_valid_out,
    output logic              fft_in_last_out,
    input  logic              fft_in_ready_in,
    input  logic              fft_out_valid_in,
    input  logic              fft_out_ready_in,
    input  logic              fft_out_last_in,
    output logic              frame_done_out,
    output logic [15:0]       frame_count_out,
    output logic              overrun_out,
    output logic              timeout_out,
    output logic              busy_out
);

    localparam int BEAT_W = $clog2(FRAME_LEN);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_CONFIG,
        ST_IDLE,
        ST_FILL,
        ST_WAIT_OUT
    } state_t;

    state_t              state_q,      state_d;
    logic                cfg_valid_q,  cfg_valid_d;
    logic                hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]   hold_data_q,  hold_data_d;
    logic [BEAT_W-1:0]   beat_idx_q,   beat_idx_d;
    logic [WAIT_W-1:0]   wait_cnt_q,   wait_cnt_d;
    logic                done_q,       done_d;
    logic [15:0]         count_q,      count_d;
    logic                overrun_q,    overrun_d;
    logic                timeout_q,    timeout_d;

    logic                in_hs;
    logic                hold_is_last;
    logic                out_done;
    logic [15:0]         sample_ext;

    // The holding register only ever holds data while in FILL, so its valid
    // bit doubles as the FFT input valid.
    assign in_hs        = hold_valid_q & fft_in_ready_in;
    // beat_idx is the frame position of the beat currently held.
    assign hold_is_last = (beat_idx_q == BEAT_LAST);
    assign out_done     = fft_out_valid_in & fft_out_ready_in & fft_out_last_in;
    assign sample_ext   = 16'(signed'(hold_data_q));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_CONFIG;
            cfg_valid_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            beat_idx_q   <= '0;
            wait_cnt_q   <= '0;
            done_q       <= 1'b0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_valid_q  <= cfg_valid_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            beat_idx_q   <= beat_idx_d;
            wait_cnt_q   <= wait_cnt_d;
            done_q       <= done_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cfg_valid_d  = cfg_valid_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        beat_idx_d   = beat_idx_q;
        wait_cnt_d   = wait_cnt_q;
        done_d       = 1'b0;
        count_d      = count_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;

        case (state_q)
            ST_CONFIG: begin
                // Valid is registered so it stays low during reset and
                // rises on the first edge after release.
                if (cfg_valid_q && fft_config_ready_in) begin
                    cfg_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cfg_valid_d = 1'b1;
                end
            end

            ST_IDLE: begin
                if (enable_in) begin
                    state_d = ST_FILL;
                end
            end

            ST_FILL: begin
                if (in_hs) begin
                    hold_valid_d = 1'b0;
                    if (hold_is_last) begin
                        beat_idx_d = '0;
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT_OUT;
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end
                end
                // Once the last beat is held, the frame is full: extra
                // samples are discarded without flagging an overrun.
                if (sample_valid_in && !(hold_valid_q && hold_is_last)) begin
                    if (!hold_valid_q || in_hs) begin
                        hold_valid_d = 1'b1;
                        hold_data_d  = sample_in;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end

            ST_WAIT_OUT: begin
                // Completion takes priority over an expiring timeout.
                if (out_done) begin
                    done_d     = 1'b1;
                    count_d    = count_q + 16'd1;
                    wait_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: state_d = ST_CONFIG;
        endcase
    end

    assign fft_config_data_out  = CONFIG_WORD;
    assign fft_config_valid_out = cfg_valid_q;
    assign fft_in_data_out      = {16'h0000, sample_ext};
    assign fft_in_valid_out     = hold_valid_q;
    assign fft_in_last_out      = hold_valid_q & hold_is_last;
    assign frame_done_out       = done_q;
    assign frame_count_out      = count_q;
    assign overrun_out          = overrun_q;
    assign timeout_out          = timeout_q;
    assign busy_out             = (state_q == ST_FILL) || (state_q == ST_WAIT_OUT);

endmodule

// File: tb/tb_fft_frame_controller.sv
// tb/tb_fft_frame_controller.sv - self-checking bench for fft_frame_controller

module tb_fft_frame_controller;

    localparam int FL = 8;
    localparam int DW = 12;
    localparam int TO = 32;

    logic          clk, rst, enable, sample_valid, cfg_ready, in_ready;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] sample;
    logic [15:0]   cfg_data, count;
    logic [31:0]   in_data;
    logic          cfg_valid, in_valid, in_last, done, overrun, timeout, busy;

    int            tests, fails;
    logic [32:0]   obs_q[$];
    logic [DW-1:0] exp_q[$];
    int            model_pend, model_acc, exp_count;
    logic          exp_over;
    int            cfg_high_cnt, cfg_hs_cnt;

    fft_frame_controller #(
        .FRAME_LEN(FL), .DATA_W(DW), .CONFIG_WORD(16'h0001), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk), .rst_in(rst), .enable_in(enable),
        .sample_in(sample), .sample_valid_in(sample_valid),
        .fft_config_data_out(cfg_data), .fft_config_valid_out(cfg_valid),
        .fft_config_ready_in(cfg_ready),
        .fft_in_data_out(in_data), .fft_in_valid_out(in_valid),
        .fft_in_last_out(in_last), .fft_in_ready_in(in_ready),
        .fft_out_valid_in(out_valid), .fft_out_ready_in(out_ready),
        .fft_out_last_in(out_last),
        .frame_done_out(done), .frame_count_out(count),
        .overrun_out(overrun), .timeout_out(timeout), .busy_out(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ext(input logic [DW-1:0] s);
        int v;
        v = $signed(s);
        return {16'h0000, v[15:0]};
    endfunction

    // Records handshakes just before the edge, then moves to 1 time unit
    // after the edge where outputs are stable.
    task automatic step();
        if (in_valid && in_ready) obs_q.push_back({in_last, in_data});
        if (cfg_valid) cfg_high_cnt++;
        if (cfg_valid && cfg_ready) cfg_hs_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Drives one FILL cycle and advances the reference model: a frame takes
    // FL samples; a sample is taken if the single slot is free or emptying
    // this cycle, dropped (overrun) if not, ignored once the frame is full.
    task automatic fill_cycle(input logic sv, input logic [DW-1:0] s, input logic r);
        logic drain, took;
        sample_valid = sv;
        sample       = s;
        in_ready     = r;
        drain = (model_pend != 0) && r;
        took  = 1'b0;
        if (sv && model_acc < FL) begin
            if (model_pend == 0 || drain) begin
                exp_q.push_back(s);
                model_acc++;
                took = 1'b1;
            end else begin
                exp_over = 1'b1;
            end
        end
        model_pend = (((model_pend != 0) && !drain) || took) ? 1 : 0;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic new_frame();
        obs_q.delete();
        exp_q.delete();
        model_pend = 0;
        model_acc  = 0;
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    task automatic drain_fill();
        for (int k = 0; k < 40 && obs_q.size() < FL; k++) fill_cycle(1'b0, '0, 1'b1);
    endtask

    task automatic out_last_beat();
        out_valid = 1'b1; out_ready = 1'b1; out_last = 1'b1;
        step();
        out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests++;
        if ({cfg_valid, in_valid, in_last, done, overrun, timeout, busy} !== 7'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {cfg_valid, in_valid, in_last, done, overrun, timeout, busy});
        end
        tests++;
        if (cfg_data !== 16'h0001 || in_data !== 32'h0 || count !== 16'h0) begin
            fails++;
            $display("FAIL reset_words: cfg=%h data=%h count=%h want 0001/0/0", cfg_data, in_data, count);
        end
    endtask

    task automatic test_config();
        cfg_ready = 1'b0;
        cfg_high_cnt = 0;
        cfg_hs_cnt = 0;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step();
        tests++;
        if (cfg_valid !== 1'b1) begin
            fails++;
            $display("FAIL config_valid_held: got %b want 1", cfg_valid);
        end
        cfg_ready = 1'b1;
        step();
        step();
        step();
        cfg_ready = 1'b0;
        tests++;
        if (cfg_high_cnt != 6 || cfg_hs_cnt != 1 || cfg_valid !== 1'b0) begin
            fails++;
            $display("FAIL config_handshake: high=%0d hs=%0d valid=%b want 6/1/0",
                     cfg_high_cnt, cfg_hs_cnt, cfg_valid);
        end
        tests++;
        if (cfg_data !== 16'h0001 || busy !== 1'b0) begin
            fails++;
            $display("FAIL config_data: got %h busy=%b want 0001 busy=0", cfg_data, busy);
        end
    endtask

    task automatic test_frame();
        logic [32:0] e;
        in_ready = 1'b1;
        sample_valid = 1'b1;
        sample = 12'h123;
        step();
        step();
        sample_valid = 1'b0;
        tests++;
        if (in_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_discard: valid=%b overrun=%b busy=%b want 0/0/0", in_valid, overrun, busy);
        end
        new_frame();
        tests++;
        if (busy !== 1'b1 || in_valid !== 1'b0) begin
            fails++;
            $display("FAIL fill_entry: busy=%b valid=%b want 1/0", busy, in_valid);
        end
        for (int i = 0; i < FL; i++) fill_cycle(1'b1, DW'(i - 8), 1'b1);
        tests++;
        if (obs_q.size() != FL - 1 || in_valid !== 1'b1 || in_last !== 1'b1) begin
            fails++;
            $display("FAIL frame_throughput: beats=%0d valid=%b last=%b want 7/1/1",
                     obs_q.size(), in_valid, in_last);
        end
        drain_fill();
        tests++;
        if (obs_q.size() != FL) begin
            fails++;
            $display("FAIL frame_beats: got %0d want %0d", obs_q.size(), FL);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            e = {(i == FL - 1), 16'h0000, 16'(i - 8)};
            tests++;
            if (obs_q[i] !== e) begin
                fails++;
                $display("FAIL frame_beat%0d: got %h want %h", i, obs_q[i], e);
            end
        end
        tests++;
        if (busy !== 1'b1 || in_valid !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL wait_out: busy=%b valid=%b done=%b want 1/0/0", busy, in_valid, done);
        end
        out_last_beat();
        exp_count++;
        tests++;
        if (done !== 1'b1 || count !== 16'(exp_count)) begin
            fails++;
            $display("FAIL frame_done: done=%b count=%0d want 1/%0d", done, count, exp_count);
        end
        step();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse_width: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_stall();
        new_frame();
        for (int c = 0; c < 2 * FL; c++)
            fill_cycle((c % 2) == 0, DW'($urandom), (c % 2) == 0);
        drain_fill();
        tests++;
        if (overrun !== 1'b0 || exp_over !== 1'b0 || obs_q.size() != FL) begin
            fails++;
            $display("FAIL stall_no_loss: overrun=%b beats=%0d want 0/%0d", overrun, obs_q.size(), FL);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (obs_q[i] !== {(i == FL - 1), ext(exp_q[i])}) begin
                fails++;
                $display("FAIL stall_beat%0d: got %h want %h", i, obs_q[i], {(i == FL - 1), ext(exp_q[i])});
            end
        end
        out_last_beat();
        exp_count++;
        tests++;
        if (done !== 1'b1 || count !== 16'(exp_count)) begin
            fails++;
            $display("FAIL stall_done: done=%b count=%0d want 1/%0d", done, count, exp_count);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a, b;
        a = DW'($urandom);
        b = ~a;
        new_frame();
        fill_cycle(1'b1, a, 1'b0);
        fill_cycle(1'b1, b, 1'b0);
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL bp_overrun: got %b want 1", overrun);
        end
        for (int k = 0; k < 3; k++) begin
            fill_cycle(1'b0, '0, 1'b0);
            tests++;
            if (in_valid !== 1'b1 || in_last !== 1'b0 || in_data !== ext(a)) begin
                fails++;
                $display("FAIL bp_hold%0d: valid=%b last=%b data=%h want 1/0/%h", k, in_valid, in_last, in_data, ext(a));
            end
        end
        for (int i = 0; i < FL - 1; i++) fill_cycle(1'b1, DW'($urandom), 1'b1);
        drain_fill();
        tests++;
        if (obs_q.size() != FL || obs_q[0] !== {1'b0, ext(a)}) begin
            fails++;
            $display("FAIL bp_first_beat: beats=%0d first=%h want %0d/%h", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : 33'h0, FL, {1'b0, ext(a)});
        end
        out_last_beat();
        exp_count++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            new_frame();
            for (int k = 0; k < 200 && obs_q.size() < FL; k++)
                fill_cycle(1'($urandom), DW'($urandom), 1'($urandom));
            tests++;
            if (obs_q.size() != FL || overrun !== exp_over) begin
                fails++;
                $display("FAIL rand%0d_frame: beats=%0d overrun=%b want %0d/%b", f, obs_q.size(), overrun, FL, exp_over);
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                tests++;
                if (obs_q[i] !== {(i == FL - 1), ext(exp_q[i])}) begin
                    fails++;
                    $display("FAIL rand%0d_beat%0d: got %h want %h", f, i, obs_q[i], {(i == FL - 1), ext(exp_q[i])});
                end
            end
            out_last_beat();
            exp_count++;
            tests++;
            if (done !== 1'b1 || count !== 16'(exp_count)) begin
                fails++;
                $display("FAIL rand%0d_done: done=%b count=%0d want 1/%0d", f, done, count, exp_count);
            end
        end
    endtask

    task automatic test_completion_wins();
        new_frame();
        for (int i = 0; i < FL; i++) fill_cycle(1'b1, DW'($urandom), 1'b1);
        drain_fill();
        // Valid and last without downstream ready is not a completion.
        out_valid = 1'b1; out_last = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < TO - 1; k++) step();
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL no_ready_no_done: busy=%b done=%b timeout=%b want 1/0/0", busy, done, timeout);
        end
        out_last_beat();
        exp_count++;
        tests++;
        if (done !== 1'b1 || timeout !== 1'b0 || count !== 16'(exp_count)) begin
            fails++;
            $display("FAIL completion_wins: done=%b timeout=%b count=%0d want 1/0/%0d", done, timeout, count, exp_count);
        end
    endtask

    task automatic test_timeout();
        new_frame();
        for (int i = 0; i < FL; i++) fill_cycle(1'b1, DW'($urandom), 1'b1);
        drain_fill();
        for (int k = 0; k < TO - 1; k++) step();
        tests++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early: timeout=%b busy=%b want 0/1", timeout, busy);
        end
        step();
        tests++;
        if (timeout !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || count !== 16'(exp_count)) begin
            fails++;
            $display("FAIL timeout: timeout=%b busy=%b done=%b count=%0d want 1/0/0/%0d",
                     timeout, busy, done, count, exp_count);
        end
        new_frame();
        tests++;
        if (busy !== 1'b1 || timeout !== 1'b1) begin
            fails++;
            $display("FAIL after_timeout_start: busy=%b timeout=%b want 1/1", busy, timeout);
        end
        for (int i = 0; i < FL; i++) fill_cycle(1'b1, DW'($urandom), 1'b1);
        drain_fill();
        out_last_beat();
        exp_count++;
    endtask

    task automatic test_reset_mid();
        new_frame();
        for (int i = 0; i < 5; i++) fill_cycle(1'b1, DW'($urandom), 1'b1);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({cfg_valid, in_valid, in_last, done, overrun, timeout, busy} !== 7'b0 ||
            count !== 16'h0 || in_data !== 32'h0 || cfg_data !== 16'h0001) begin
            fails++;
            $display("FAIL reset_async: flags=%b count=%0d data=%h want 0/0/0",
                     {cfg_valid, in_valid, in_last, done, overrun, timeout, busy}, count, in_data);
        end
        exp_count = 0;
        exp_over = 1'b0;
        cfg_high_cnt = 0;
        cfg_hs_cnt = 0;
        cfg_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        tests++;
        if (cfg_valid !== 1'b1) begin
            fails++;
            $display("FAIL reconfig_valid: got %b want 1", cfg_valid);
        end
        cfg_ready = 1'b1;
        step();
        cfg_ready = 1'b0;
        tests++;
        if (cfg_hs_cnt != 1 || cfg_valid !== 1'b0) begin
            fails++;
            $display("FAIL reconfig_hs: hs=%0d valid=%b want 1/0", cfg_hs_cnt, cfg_valid);
        end
        new_frame();
        for (int i = 0; i < FL; i++) fill_cycle(1'b1, DW'($urandom), 1'b1);
        drain_fill();
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (obs_q[i] !== {(i == FL - 1), ext(exp_q[i])}) begin
                fails++;
                $display("FAIL post_reset_beat%0d: got %h want %h", i, obs_q[i], {(i == FL - 1), ext(exp_q[i])});
            end
        end
        out_last_beat();
        exp_count++;
        tests++;
        if (obs_q.size() != FL || count !== 16'(exp_count)) begin
            fail_line: begin
                fails++;
                $display("FAIL post_reset_frame: beats=%0d count=%0d want %0d/%0d", obs_q.size(), count, FL, exp_count);
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample = '0;
        cfg_ready = 1'b0; in_ready = 1'b0;
        out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
        model_pend = 0; model_acc = 0; exp_count = 0; exp_over = 1'b0;
        cfg_high_cnt = 0; cfg_hs_cnt = 0;
        test_reset();
        test_config();
        test_frame();
        test_stall();
        test_backpressure();
        test_random();
        test_completion_wins();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
